// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The sub member exists only when SERIAL_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

`ifdef SERIAL_SUB_EN
  modport master (
    output start, a, b, sub,
    input  busy, done, sum, carry_out
  );
  modport slave (
    input  start, a, b, sub,
    output busy, done, sum, carry_out
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, sum, carry_out
  );
  modport slave (
    input  start, a, b,
    output busy, done, sum, carry_out
  );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/sub controller: one shared adder cell, LSB first.
// SERIAL_SUB_EN adds the sub request (A - B, carry_out = no-borrow).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;

  logic w_sub;
  logic w_accept;
  logic w_last;
  logic w_h1_s;
  logic w_h1_c;
  logic w_h2_s;
  logic w_h2_c;
  logic w_c_nxt;

`ifdef SERIAL_SUB_EN
  assign w_sub = bus.sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_cnt == LAST);

  // Two cascaded half adders plus an OR form the shared full adder
  assign w_h1_s  = r_a[0] ^ r_b[0];
  assign w_h1_c  = r_a[0] & r_b[0];
  assign w_h2_s  = w_h1_s ^ r_c;
  assign w_h2_c  = w_h1_s & r_c;
  assign w_c_nxt = w_h1_c | w_h2_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // b is stored pre-inverted for subtraction so RUN never looks at sub
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= w_sub ? ~bus.b : bus.b;
      r_cnt <= '0;
      r_c   <= w_sub;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + CW'(1);
      r_c   <= w_c_nxt;
      r_sum <= {w_h2_s, r_sum[WIDTH-1:1]};
      if (w_last) r_cout <= w_c_nxt;
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=4.
// Sub cases run when SERIAL_SUB_EN is defined.
module tb_serial_adder_ctrl;

  localparam int W  = 8;
  localparam int W4 = 4;
`ifdef SERIAL_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sub8 = 1'b0;
  logic msub;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W))  bus8 ();
  serial_adder_ctrl_if #(.WIDTH(W4)) bus4 ();

`ifdef SERIAL_SUB_EN
  assign bus8.sub = sub8;
  assign bus4.sub = 1'b0;
`endif
  assign msub = sub8 & SUB_ON;

  serial_adder_ctrl #(.WIDTH(W)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_adder_ctrl #(.WIDTH(W4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref8(input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [W4:0] ref4(input logic [W4-1:0] a,
                                       input logic [W4-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  int m8_cnt;
  int m4_cnt;
  logic [W:0]  q8[$];
  logic [W4:0] q4[$];
  logic [W:0]  last8;
  logic [W4:0] last4;
  int d8 = 0;
  int d4 = 0;

  // Reference timing: busy for W+1 cycles after accept, done on the last
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_cnt <= 0;
      m4_cnt <= 0;
      q8.delete();
      q4.delete();
    end else begin
      if (m8_cnt == 0) begin
        if (bus8.start) begin
          m8_cnt <= W + 1;
          q8.push_back(ref8(bus8.a, bus8.b, msub));
        end
      end else m8_cnt <= m8_cnt - 1;
      if (m4_cnt == 0) begin
        if (bus4.start) begin
          m4_cnt <= W4 + 1;
          q4.push_back(ref4(bus4.a, bus4.b));
        end
      end else m4_cnt <= m4_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last8 = '0;
      last4 = '0;
    end
    chk("busy8", bus8.busy, m8_cnt != 0);
    chk("done8", bus8.done, m8_cnt == 1);
    if (m8_cnt == 1) begin
      d8++;
      chk("q8len", q8.size(), 1);
      if (q8.size() > 0) last8 = q8.pop_front();
    end
    if (m8_cnt <= 1)
      chk("res8", {bus8.carry_out, bus8.sum}, last8);
    chk("busy4", bus4.busy, m4_cnt != 0);
    chk("done4", bus4.done, m4_cnt == 1);
    if (m4_cnt == 1) begin
      d4++;
      chk("q4len", q4.size(), 1);
      if (q4.size() > 0) last4 = q4.pop_front();
    end
    if (m4_cnt <= 1)
      chk("res4", {bus4.carry_out, bus4.sum}, last4);
  end

  task automatic op8(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s);
    int n;
    int dn;
    int lat;
    @(negedge clk);
    bus8.a = a;
    bus8.b = b;
    sub8 = s;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 0;
    dn = 0;
    lat = 0;
    while (bus8.busy && n < 40) begin
      n++;
      if (bus8.done) begin
        dn++;
        lat = n;
      end
      @(negedge clk);
    end
    chk("blen8", n, W + 1);
    chk("dcnt8", dn, 1);
    chk("lat8", lat, W + 1);
  endtask

  task automatic op4(input logic [W4-1:0] a, input logic [W4-1:0] b);
    int n;
    int lat;
    @(negedge clk);
    bus4.a = a;
    bus4.b = b;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    n = 0;
    lat = 0;
    while (bus4.busy && n < 40) begin
      n++;
      if (bus4.done) lat = n;
      @(negedge clk);
    end
    chk("blen4", n, W4 + 1);
    chk("lat4", lat, W4 + 1);
  endtask

  initial begin
    int dref;
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus4.start = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sum8", bus8.sum, 0);
    chk("rst_co8", bus8.carry_out, 0);
    rst_n = 1'b1;

    op8(8'h00, 8'h00, 1'b0);
    op8(8'h5A, 8'h3C, 1'b0);
    chk("sum5a3c", bus8.sum, 8'h96);
    chk("co5a3c", bus8.carry_out, 0);
    op8(8'hFF, 8'h01, 1'b0);
    chk("sumff01", bus8.sum, 8'h00);
    chk("coff01", bus8.carry_out, 1);
    op8(8'h80, 8'h80, 1'b0);
    op8(8'h7F, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++)
      op8(W'($urandom), W'($urandom), 1'b0);

    if (SUB_ON) begin
      op8(8'h10, 8'h01, 1'b1);
      chk("sub1001", {bus8.carry_out, bus8.sum}, 9'h10F);
      op8(8'h00, 8'h01, 1'b1);
      chk("sub0001", {bus8.carry_out, bus8.sum}, 9'h0FF);
      op8(8'h42, 8'h42, 1'b1);
      for (int i = 0; i < 3; i++)
        op8(W'($urandom), W'($urandom), 1'b1);
      sub8 = 1'b0;
    end

    // Start held high: accepts every W+2 edges
    dref = d8;
    @(negedge clk);
    bus8.a = 8'h01;
    bus8.b = 8'h01;
    bus8.start = 1'b1;
    repeat (30) @(negedge clk);
    chk("held_dn", d8 - dref, 3);
    chk("held_sum", bus8.sum, 8'h02);
    for (int i = 0; i < 40; i++) begin
      bus8.a = W'($urandom);
      bus8.b = W'($urandom);
      @(negedge clk);
    end
    bus8.start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset mid-RUN discards the operation
    bus8.a = 8'hF0;
    bus8.b = 8'h0F;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", bus8.busy, 0);
    chk("ar_done", bus8.done, 0);
    chk("ar_sum", bus8.sum, 0);
    chk("ar_co", bus8.carry_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dref = d8;
    repeat (15) @(negedge clk);
    chk("ar_nodone", d8 - dref, 0);
    op8(8'hF0, 8'h0F, 1'b0);
    chk("post_rst", {bus8.carry_out, bus8.sum}, 9'h0FF);

    op4(4'hF, 4'hF);
    chk("sum4ff", {bus4.carry_out, bus4.sum}, 5'h1E);
    op4(4'h3, 4'h4);
    op4(4'h8, 4'h8);
    for (int i = 0; i < 3; i++)
      op4(W4'($urandom), W4'($urandom));

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
